flame_spreader: RTL and testbench

Producer of the per-cell explosion mask for the 16x16 play field. Accepts bomb detonation requests (cell index plus flame power) through a 4-entry queue. For each request it walks the flame outward in four directions against the current wall grid, then drives `o_explode[255:0]` for a fixed hold window. Its output feeds the wall block's `i_explode` input, and it reads that block's `o_wall_grid` back.

---
 rtl/flame_spreader.sv | 243 ++++++++++++++++++++++++
 tb/tb_flame_spreader.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/flame_spreader.sv
// flame_spreader: queues bomb detonations, walks each flame outward over the
// 16x16 wall grid one target cell per cycle, then holds the explosion mask
// for HOLD_CYCLES cycles.
// Build option: define FLAME_PIERCE_EN to let flames pass through ABLE_WALL
// cells (the wall is still marked); UNABLE_WALL blocks in both builds.
module flame_spreader #(
   parameter int unsigned HOLD_CYCLES = 8,
   parameter int unsigned FIFO_DEPTH  = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_det_valid,
   output logic         o_det_ready,
   input  logic [7:0]   i_det_pos,
   input  logic [2:0]   i_det_power,
   input  logic [1:0]   i_wall_grid [0:255],
   output logic [255:0] o_explode,
   output logic         o_busy,
   output logic         o_done
);

   localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

   typedef enum logic [1:0] {ST_IDLE, ST_SPREAD, ST_HOLD} state_t;
   typedef enum logic [1:0] {DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT} dir_t;

   // request queue
   logic [7:0]    r_fifo_pos [0:FIFO_DEPTH-1];
   logic [2:0]    r_fifo_pow [0:FIFO_DEPTH-1];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;
   logic          w_push;
   logic          w_pop;
   logic [2:0]    w_push_pow;

   // walker state
   state_t        r_state;
   state_t        w_state_nxt;
   dir_t          r_dir;
   dir_t          w_dir_nxt;
   logic [2:0]    r_step;
   logic [2:0]    w_step_nxt;
   logic [7:0]    r_pos;
   logic [7:0]    w_pos_nxt;
   logic [2:0]    r_power;
   logic [2:0]    w_power_nxt;
   logic [255:0]  r_mask;
   logic [255:0]  w_mask_nxt;
   logic [255:0]  r_explode;
   logic [255:0]  w_explode_nxt;
   logic [7:0]    r_cnt;
   logic [7:0]    w_cnt_nxt;
   logic          r_busy;
   logic          r_done;
   logic          w_mark;
   logic          w_dir_end;

   // target cell geometry
   logic [4:0]    w_row5;
   logic [4:0]    w_col5;
   logic [4:0]    w_step5;
   logic [4:0]    w_rsub;
   logic [4:0]    w_radd;
   logic [4:0]    w_csub;
   logic [4:0]    w_cadd;
   logic          w_oob;
   logic [7:0]    w_tidx;
   logic [1:0]    w_cell;

   function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
      return (p == AW'(FIFO_DEPTH - 1)) ? '0 : p + AW'(1);
   endfunction

   assign o_det_ready = (r_count != CW'(FIFO_DEPTH));
   assign w_push      = i_det_valid && o_det_ready;
   assign w_push_pow  = (i_det_power == 3'd0) ? 3'd1 : i_det_power;

   // queue storage: written on accepted pushes only, no reset needed
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_fifo_pos[r_wr_ptr] <= i_det_pos;
         r_fifo_pow[r_wr_ptr] <= w_push_pow;
      end
   end

   // queue pointers and occupancy; simultaneous push and pop leave count unchanged
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
         if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
         r_count <= r_count + CW'(w_push) - CW'(w_pop);
      end
   end

   // row/col arithmetic in 5 bits: bit 4 flags leaving the 0..15 range
   assign w_row5  = {1'b0, r_pos[7:4]};
   assign w_col5  = {1'b0, r_pos[3:0]};
   assign w_step5 = {2'b00, r_step};
   assign w_rsub  = w_row5 - w_step5;
   assign w_radd  = w_row5 + w_step5;
   assign w_csub  = w_col5 - w_step5;
   assign w_cadd  = w_col5 + w_step5;

   // select the single target cell for the current direction and step
   always_comb begin
      w_oob  = 1'b0;
      w_tidx = r_pos;
      case (r_dir)
         DIR_UP: begin
            w_oob  = w_rsub[4];
            w_tidx = {w_rsub[3:0], r_pos[3:0]};
         end
         DIR_DOWN: begin
            w_oob  = w_radd[4];
            w_tidx = {w_radd[3:0], r_pos[3:0]};
         end
         DIR_LEFT: begin
            w_oob  = w_csub[4];
            w_tidx = {r_pos[7:4], w_csub[3:0]};
         end
         default: begin
            w_oob  = w_cadd[4];
            w_tidx = {r_pos[7:4], w_cadd[3:0]};
         end
      endcase
   end

   assign w_cell = i_wall_grid[w_tidx];

   // state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_state_nxt;
   end

   // next-state, flame walk and hold countdown
   always_comb begin
      w_state_nxt   = r_state;
      w_dir_nxt     = r_dir;
      w_step_nxt    = r_step;
      w_pos_nxt     = r_pos;
      w_power_nxt   = r_power;
      w_mask_nxt    = r_mask;
      w_explode_nxt = r_explode;
      w_cnt_nxt     = r_cnt;
      w_pop         = 1'b0;
      w_mark        = 1'b0;
      w_dir_end     = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (r_count != '0) begin
               w_pop       = 1'b1;
               w_pos_nxt   = r_fifo_pos[r_rd_ptr];
               w_power_nxt = r_fifo_pow[r_rd_ptr];
               w_mask_nxt  = '0;
               w_mask_nxt[r_fifo_pos[r_rd_ptr]] = 1'b1;
               w_dir_nxt   = DIR_UP;
               w_step_nxt  = 3'd1;
               w_state_nxt = ST_SPREAD;
            end
         end
         ST_SPREAD: begin
            if (w_oob) begin
               w_dir_end = 1'b1;
            end else begin
               case (w_cell)
                  2'd0: begin
                     w_mark    = 1'b1;
                     w_dir_end = (r_step == r_power);
                  end
                  2'd1: begin
                     w_mark    = 1'b1;
`ifdef FLAME_PIERCE_EN
                     w_dir_end = (r_step == r_power);
`else
                     w_dir_end = 1'b1;
`endif
                  end
                  default: w_dir_end = 1'b1;
               endcase
            end
            if (w_mark) w_mask_nxt[w_tidx] = 1'b1;
            if (w_dir_end) begin
               w_step_nxt = 3'd1;
               if (r_dir == DIR_RIGHT) begin
                  w_explode_nxt = w_mask_nxt;
                  w_cnt_nxt     = 8'(HOLD_CYCLES - 1);
                  w_state_nxt   = ST_HOLD;
               end else begin
                  w_dir_nxt = dir_t'(r_dir + 2'd1);
               end
            end else begin
               w_step_nxt = r_step + 3'd1;
            end
         end
         ST_HOLD: begin
            if (r_cnt == 8'd0) begin
               w_explode_nxt = '0;
               w_state_nxt   = ST_IDLE;
            end else begin
               w_cnt_nxt = r_cnt - 8'd1;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // datapath registers; busy and done are registered from the next state
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_dir     <= DIR_UP;
         r_step    <= 3'd1;
         r_pos     <= '0;
         r_power   <= '0;
         r_mask    <= '0;
         r_explode <= '0;
         r_cnt     <= '0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         r_dir     <= w_dir_nxt;
         r_step    <= w_step_nxt;
         r_pos     <= w_pos_nxt;
         r_power   <= w_power_nxt;
         r_mask    <= w_mask_nxt;
         r_explode <= w_explode_nxt;
         r_cnt     <= w_cnt_nxt;
         r_busy    <= (w_state_nxt != ST_IDLE);
         r_done    <= (w_state_nxt == ST_HOLD) && (w_cnt_nxt == 8'd0);
      end
   end

   assign o_explode = r_explode;
   assign o_busy    = r_busy;
   assign o_done    = r_done;

endmodule

// File: tb/tb_flame_spreader.sv
// Bench for flame_spreader: table of directed detonations, queue and reset
// sequences, then random grids checked against a cell-walking model.
// Honours FLAME_PIERCE_EN for its expectations.
module tb_flame_spreader;

   localparam int HOLD = 8;
`ifdef FLAME_PIERCE_EN
   localparam bit PIERCE = 1'b1;
`else
   localparam bit PIERCE = 1'b0;
`endif

   logic         clk;
   logic         rst;
   logic         i_det_valid;
   logic         o_det_ready;
   logic [7:0]   i_det_pos;
   logic [2:0]   i_det_power;
   logic [1:0]   grid [0:255];
   logic [255:0] o_explode;
   logic         o_busy;
   logic         o_done;

   flame_spreader #(.HOLD_CYCLES(HOLD), .FIFO_DEPTH(4)) dut (
      .clk         (clk),
      .rst         (rst),
      .i_det_valid (i_det_valid),
      .o_det_ready (o_det_ready),
      .i_det_pos   (i_det_pos),
      .i_det_power (i_det_power),
      .i_wall_grid (grid),
      .o_explode   (o_explode),
      .o_busy      (o_busy),
      .o_done      (o_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   // ---------------- window monitor ----------------
   typedef struct {
      logic [255:0] mask;
      int           len;
      bit           stable;
      int           done_at;
      int           done_n;
      int           spread;
   } win_t;

   win_t win_q[$];
   win_t cur;
   bit   in_win     = 1'b0;
   int   spread_cnt = 0;
   int   done_total = 0;
   int   stray_done = 0;

   always @(negedge clk) begin
      if (rst) begin
         in_win     = 1'b0;
         spread_cnt = 0;
      end else begin
         if (o_done) done_total++;
         if (o_busy && o_explode == '0) spread_cnt++;
         if (o_explode != '0) begin
            if (!in_win) begin
               in_win      = 1'b1;
               cur.mask    = o_explode;
               cur.len     = 0;
               cur.stable  = 1'b1;
               cur.done_at = 0;
               cur.done_n  = 0;
               cur.spread  = spread_cnt;
               spread_cnt  = 0;
            end else if (o_explode != cur.mask) begin
               cur.stable = 1'b0;
            end
            cur.len++;
            if (o_done) begin
               cur.done_n++;
               cur.done_at = cur.len;
            end
         end else begin
            if (o_done) stray_done++;
            if (in_win) begin
               win_q.push_back(cur);
               in_win = 1'b0;
            end
         end
      end
   end

   // ---------------- reference model ----------------
   function automatic void model(input logic [7:0] pos, input int pw,
                                 output logic [255:0] m, output int cyc);
      int dr[4] = '{-1, 1, 0, 0};
      int dc[4] = '{0, 0, -1, 1};
      int p, r, c, rr, cc;
      p   = (pw == 0) ? 1 : pw;
      r   = int'(pos[7:4]);
      c   = int'(pos[3:0]);
      m   = '0;
      m[pos] = 1'b1;
      cyc = 0;
      for (int d = 0; d < 4; d++) begin
         for (int s = 1; s <= p; s++) begin
            cyc++;
            rr = r + dr[d] * s;
            cc = c + dc[d] * s;
            if (rr < 0 || rr > 15 || cc < 0 || cc > 15) break;
            if (grid[rr * 16 + cc] >= 2'd2) break;
            m[rr * 16 + cc] = 1'b1;
            if (grid[rr * 16 + cc] == 2'd1 && !PIERCE) break;
         end
      end
   endfunction

   function automatic logic [255:0] bits_of(input logic [127:0] list, input int n);
      logic [255:0] m = '0;
      for (int k = 0; k < n; k++) m[list[8*k +: 8]] = 1'b1;
      return m;
   endfunction

   // ---------------- stimulus helpers ----------------
   task automatic clear_grid();
      for (int k = 0; k < 256; k++) grid[k] = 2'd0;
   endtask

   task automatic push(input logic [7:0] p, input logic [2:0] w);
      int t = 0;
      i_det_valid = 1'b1;
      i_det_pos   = p;
      i_det_power = w;
      @(negedge clk);
      while (!o_det_ready && t < 200) begin
         @(negedge clk);
         t++;
      end
      if (t >= 200) begin
         n_checks++;
         $display("FAIL push_timeout: ready stayed %b, expected 1", o_det_ready);
      end
      @(posedge clk);
      #1;
      i_det_valid = 1'b0;
   endtask

   task automatic wait_windows(input string name, input int n, input int budget);
      int t = 0;
      while (win_q.size() < n && t < budget) begin
         @(posedge clk);
         t++;
      end
      #1;
      check(name, 256'(win_q.size()), 256'(n));
   endtask

   task automatic check_window(input string name, input logic [255:0] exp_mask, input int exp_spread);
      win_t w;
      if (win_q.size() == 0) return;
      w = win_q.pop_front();
      check({name, "_mask"},   w.mask, exp_mask);
      check({name, "_spread"}, 256'(w.spread), 256'(exp_spread));
      check({name, "_len"},    256'(w.len), 256'(HOLD));
      check({name, "_stable"}, 256'(w.stable), 256'(1));
      check({name, "_done"},   256'({w.done_n, w.done_at}), 256'({32'd1, 32'(HOLD)}));
   endtask

   // ---------------- directed table ----------------
   typedef struct {
      logic [7:0]   pos;
      logic [2:0]   pow;
      bit           has_able;
      logic [7:0]   able_at;
      bit           has_unable;
      logic [7:0]   unable_at;
      logic [255:0] exp_mask;
      int           exp_spread;
   } vec_t;

   vec_t tbl[5];

   initial begin
      logic [255:0] m;
      int           cyc;
      int           acc;
      int           done_before;
      int           t;
      logic [7:0]   qpos[6];
      int           v;

      tbl[0] = '{8'h88, 3'd2, 1'b0, 8'h00, 1'b0, 8'h00,
                 bits_of(128'({8'h88, 8'h78, 8'h68, 8'h98, 8'hA8, 8'h87, 8'h86, 8'h89, 8'h8A}), 9), 8};
      tbl[1] = '{8'h00, 3'd3, 1'b0, 8'h00, 1'b0, 8'h00,
                 bits_of(128'({8'h00, 8'h01, 8'h02, 8'h03, 8'h10, 8'h20, 8'h30}), 7), 8};
      if (PIERCE)
         tbl[2] = '{8'h88, 3'd3, 1'b1, 8'h89, 1'b1, 8'h78,
                    bits_of(128'({8'h88, 8'h98, 8'hA8, 8'hB8, 8'h87, 8'h86, 8'h85, 8'h89, 8'h8A, 8'h8B}), 10), 10};
      else
         tbl[2] = '{8'h88, 3'd3, 1'b1, 8'h89, 1'b1, 8'h78,
                    bits_of(128'({8'h88, 8'h98, 8'hA8, 8'hB8, 8'h87, 8'h86, 8'h85, 8'h89}), 8), 8};
      tbl[3] = '{8'h88, 3'd0, 1'b0, 8'h00, 1'b0, 8'h00,
                 bits_of(128'({8'h88, 8'h78, 8'h98, 8'h87, 8'h89}), 5), 4};
      tbl[4] = '{8'hFF, 3'd7, 1'b0, 8'h00, 1'b0, 8'h00,
                 bits_of(128'({8'hFF, 8'hEF, 8'hDF, 8'hCF, 8'hBF, 8'hAF, 8'h9F, 8'h8F,
                               8'hFE, 8'hFD, 8'hFC, 8'hFB, 8'hFA, 8'hF9, 8'hF8}), 15), 16};

      // reset state
      rst         = 1'b1;
      i_det_valid = 1'b0;
      i_det_pos   = '0;
      i_det_power = '0;
      clear_grid();
      #12;
      check("rst_explode", o_explode, '0);
      check("rst_busy",    256'(o_busy), 256'(0));
      check("rst_done",    256'(o_done), 256'(0));
      check("rst_ready",   256'(o_det_ready), 256'(1));
      repeat (2) @(posedge clk);
      #3 rst = 1'b0;
      @(posedge clk);
      #1;

      // directed vectors
      for (int i = 0; i < 5; i++) begin
         clear_grid();
         if (tbl[i].has_able)   grid[tbl[i].able_at]   = 2'd1;
         if (tbl[i].has_unable) grid[tbl[i].unable_at] = 2'd2;
         push(tbl[i].pos, tbl[i].pow);
         wait_windows($sformatf("vec%0d_wait", i), 1, 300);
         check_window($sformatf("vec%0d", i), tbl[i].exp_mask, tbl[i].exp_spread);
      end

      // queue backpressure: 6 back-to-back requests, only 5 accepted
      clear_grid();
      qpos = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
      acc  = 0;
      for (int i = 0; i < 6; i++) begin
         i_det_valid = 1'b1;
         i_det_pos   = qpos[acc];
         i_det_power = 3'd1;
         @(negedge clk);
         if (o_det_ready) acc++;
         @(posedge clk);
         #1;
      end
      i_det_valid = 1'b0;
      check("q_accepted", 256'(acc), 256'(5));
      check("q_ready_low", 256'(o_det_ready), 256'(0));
      wait_windows("q_wait", 5, 800);
      for (int i = 0; i < 5; i++) begin
         model(qpos[i], 1, m, cyc);
         check_window($sformatf("q%0d", i), m, cyc);
      end
      check("q_ready_back", 256'(o_det_ready), 256'(1));

      // reset on the 3rd HOLD cycle with two requests queued behind
      win_q.delete();
      push(8'h88, 3'd1);
      push(8'h44, 3'd1);
      push(8'h22, 3'd1);
      t = 0;
      @(negedge clk);
      while (o_explode == '0 && t < 300) begin
         @(negedge clk);
         t++;
      end
      check("rh_reach_hold", 256'(t < 300), 256'(1));
      repeat (2) @(negedge clk);
      done_before = done_total;
      #1 rst = 1'b1;
      #1;
      check("rh_explode", o_explode, '0);
      check("rh_ready",   256'(o_det_ready), 256'(1));
      check("rh_busy",    256'(o_busy), 256'(0));
      check("rh_done",    256'(o_done), 256'(0));
      repeat (2) @(posedge clk);
      #3 rst = 1'b0;
      repeat (60) @(posedge clk);
      #1;
      check("rh_no_windows", 256'(win_q.size()), 256'(0));
      check("rh_no_done",    256'(done_total), 256'(done_before));
      check("rh_idle",       256'(o_busy), 256'(0));

      // random grids and requests against the model
      for (int it = 0; it < 40; it++) begin
         for (int k = 0; k < 256; k++) begin
            v = $urandom_range(0, 9);
            grid[k] = (v < 6) ? 2'd0 : (v < 8) ? 2'd1 : (v == 8) ? 2'd2 : 2'd3;
         end
         i_det_pos   = 8'($urandom_range(0, 255));
         i_det_power = 3'($urandom_range(0, 7));
         model(i_det_pos, int'(i_det_power), m, cyc);
         push(i_det_pos, i_det_power);
         wait_windows($sformatf("rnd%0d_wait", it), 1, 300);
         check_window($sformatf("rnd%0d", it), m, cyc);
      end

      check("stray_done", 256'(stray_done), 256'(0));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   // global watchdog
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1);
   end

endmodule
